// File: rtl/nn_pkg.sv
// Shared fixed-point types and helpers for the network datapath.
// Layers and the classifier import this for widths and score formats.
package nn_pkg;

    localparam int FIXED_INTG = 16;
    localparam int FIXED_FRAC = 16;

    typedef struct packed {
        logic signed [FIXED_INTG-1:0] intg;
        logic [FIXED_FRAC-1:0]        frac;
    } fixed_t;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_RELU,
        ACT_SIGMOID
    } activation_t;

    function automatic int data_width(input int intg, input int frac);
        return intg + frac;
    endfunction

endpackage

// File: rtl/argmax_classifier_rise_detect.sv
// One-flop rising-edge detector on a level input.
// The flop clears on reset so a level already high at release counts as a rise.
module argmax_classifier_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) level_q <= 1'b0;
        else        level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/argmax_classifier.sv
// Final classifier: snapshots the score vector on each new result set,
// scans it one entry per cycle and holds the index/value of the maximum.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int INTG_WIDTH = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int NUM_INPUTS = 10,
    localparam int DATA_WIDTH = data_width(INTG_WIDTH, FRAC_WIDTH),
    localparam int INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inputs_ready,
    input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic [INDEX_WIDTH-1:0]       class_index,
    output logic signed [DATA_WIDTH-1:0] max_value,
    output logic                         class_valid,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam bit SINGLE = (NUM_INPUTS == 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] snap [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] best;
    logic [INDEX_WIDTH-1:0]       best_idx;
    logic [INDEX_WIDTH-1:0]       idx;

    logic start;
    logic load;
    logic last;
    logic take;
    logic signed [DATA_WIDTH-1:0] cand;
    logic signed [DATA_WIDTH-1:0] win_val;
    logic [INDEX_WIDTH-1:0]       win_idx;

    argmax_classifier_rise_detect u_rise (
        .clock (clock),
        .reset (reset),
        .level (inputs_ready),
        .rise  (start)
    );

    // A rise while scanning is dropped, not queued.
    assign load    = start && (state != SCAN);
    assign last    = (idx == LAST_IDX);
    assign cand    = snap[idx];
    assign take    = cand > best;
    assign win_val = take ? cand : best;
    assign win_idx = take ? idx : best_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nxt = SINGLE ? DONE : SCAN;
            end
            SCAN: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) snap[i] <= '0;
            best        <= '0;
            best_idx    <= '0;
            idx         <= '0;
            class_index <= '0;
            max_value   <= '0;
            class_valid <= 1'b0;
            busy        <= 1'b0;
        end else if (load) begin
            snap     <= inputs;
            best     <= inputs[0];
            best_idx <= '0;
            idx      <= ONE_IDX;
            if (SINGLE) begin
                max_value   <= inputs[0];
                class_index <= '0;
                class_valid <= 1'b1;
                busy        <= 1'b0;
            end else begin
                class_valid <= 1'b0;
                busy        <= 1'b1;
            end
        end else if (state == SCAN) begin
            best     <= win_val;
            best_idx <= win_idx;
            if (last) begin
                max_value   <= win_val;
                class_index <= win_idx;
                class_valid <= 1'b1;
                busy        <= 1'b0;
            end else begin
                idx <= idx + ONE_IDX;
            end
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: table vectors, randomized scans against a
// max-with-lowest-index model, and multi-cycle corner sequences.
module tb_argmax_classifier;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    logic               rdy4, rdy1, rdy10;
    logic signed [31:0] in4  [4];
    logic signed [31:0] in1  [1];
    logic signed [31:0] in10 [10];

    logic [1:0]  idx4;
    logic [0:0]  idx1;
    logic [3:0]  idx10;
    logic [31:0] val4, val1, val10;
    logic        vld4, vld1, vld10;
    logic        bsy4, bsy1, bsy10;

    argmax_classifier #(.NUM_INPUTS(4)) dut4 (
        .clock(clock), .reset(reset), .inputs_ready(rdy4), .inputs(in4),
        .class_index(idx4), .max_value(val4), .class_valid(vld4), .busy(bsy4)
    );

    argmax_classifier #(.NUM_INPUTS(1)) dut1 (
        .clock(clock), .reset(reset), .inputs_ready(rdy1), .inputs(in1),
        .class_index(idx1), .max_value(val1), .class_valid(vld1), .busy(bsy1)
    );

    argmax_classifier #(.NUM_INPUTS(10)) dut10 (
        .clock(clock), .reset(reset), .inputs_ready(rdy10), .inputs(in10),
        .class_index(idx10), .max_value(val10), .class_valid(vld10), .busy(bsy10)
    );

    int checks = 0;
    int errors = 0;

    int          sel = 4;
    logic        cur_valid, cur_busy;
    logic [3:0]  cur_idx;
    logic [31:0] cur_val;

    always_comb begin
        cur_valid = vld4;
        cur_busy  = bsy4;
        cur_idx   = {2'b00, idx4};
        cur_val   = val4;
        if (sel == 1) begin
            cur_valid = vld1;
            cur_busy  = bsy1;
            cur_idx   = {3'b000, idx1};
            cur_val   = val1;
        end else if (sel == 10) begin
            cur_valid = vld10;
            cur_busy  = bsy10;
            cur_idx   = idx10;
            cur_val   = val10;
        end
    end

    typedef struct packed {
        logic [0:3][31:0] s;
        logic [1:0]       idx;
        logic [31:0]      val;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic [1:0] i, input logic [31:0] v);
        vec_t t;
        t.s   = {a, b, c, d};
        t.idx = i;
        t.val = v;
        return t;
    endfunction

    // Largest signed score; earliest position wins among equals.
    function automatic int ref_idx(input logic signed [31:0] q[$]);
        logic signed [31:0] m;
        m = q[0];
        foreach (q[i]) if (q[i] > m) m = q[i];
        foreach (q[i]) if (q[i] == m) return i;
        return 0;
    endfunction

    task automatic drive(input int n, input int i, input logic signed [31:0] v);
        if (n == 1)       in1[0]  = v;
        else if (n == 4)  in4[i]  = v;
        else              in10[i] = v;
    endtask

    task automatic set_rdy(input int n, input logic r);
        if (n == 1)       rdy1  = r;
        else if (n == 4)  rdy4  = r;
        else              rdy10 = r;
    endtask

    task automatic wait_valid(inout int lat);
        while (!cur_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_scan(input string tag, input int n, input logic signed [31:0] q[$],
                            input int exp_idx, input logic [31:0] exp_val);
        int lat;
        sel = n;
        @(negedge clock);
        for (int i = 0; i < n; i++) drive(n, i, q[i]);
        set_rdy(n, 1'b1);
        @(posedge clock);
        #1;
        lat = 0;
        if (n > 1) begin
            chk({tag, " capture busy"}, 64'(cur_busy), 64'd1);
            chk({tag, " capture valid"}, 64'(cur_valid), 64'd0);
        end
        wait_valid(lat);
        chk({tag, " latency"}, 64'(lat), 64'(n - 1));
        chk({tag, " index"}, 64'(cur_idx), 64'(exp_idx));
        chk({tag, " value"}, 64'(cur_val), 64'(exp_val));
        chk({tag, " busy done"}, 64'(cur_busy), 64'd0);
        @(negedge clock);
        set_rdy(n, 1'b0);
    endtask

    vec_t tbl [7];

    initial begin
        logic signed [31:0] q[$];
        int e;
        int lat;

        rdy4 = 0;
        rdy1 = 0;
        rdy10 = 0;
        for (int i = 0; i < 4; i++) in4[i] = '0;
        for (int i = 0; i < 10; i++) in10[i] = '0;
        in1[0] = '0;

        #12;
        chk("reset index", 64'(idx4), 64'd0);
        chk("reset value", 64'(val4), 64'd0);
        chk("reset valid", 64'({vld4, vld1, vld10}), 64'd0);
        chk("reset busy", 64'({bsy4, bsy1, bsy10}), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        tbl[0] = mk(32'h00010000, 32'hFFFE0000, 32'h00038000, 32'h00004000, 2, 32'h00038000);
        tbl[1] = mk(32'hFFFB0000, 32'hFFFF0000, 32'hFFFD0000, 32'hFFF90000, 1, 32'hFFFF0000);
        tbl[2] = mk(32'h00020000, 32'h00070000, 32'h00070000, 32'h00010000, 1, 32'h00070000);
        tbl[3] = mk(32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        tbl[4] = mk(32'h80000000, 32'h80000000, 32'h80000001, 32'h7FFFFFFF, 3, 32'h7FFFFFFF);
        tbl[5] = mk(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 32'h7FFFFFFF);
        tbl[6] = mk(32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 3, 32'h00000001);

        for (int t = 0; t < 7; t++) begin
            q = {};
            for (int i = 0; i < 4; i++) q.push_back(tbl[t].s[i]);
            run_scan($sformatf("tbl%0d", t), 4, q, int'(tbl[t].idx), tbl[t].val);
        end

        for (int t = 0; t < 20; t++) begin
            q = {};
            for (int i = 0; i < 4; i++)
                q.push_back(($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 6)) - 3)
                                                       : $urandom);
            e = ref_idx(q);
            run_scan($sformatf("rnd%0d", t), 4, q, e, q[e]);
        end

        // Second rise mid-scan plus input changes after capture.
        sel = 4;
        @(negedge clock);
        in4[0] = 32'h000A0000;
        in4[1] = 32'h00140000;
        in4[2] = 32'h00050000;
        in4[3] = 32'h00010000;
        rdy4 = 1'b1;
        @(posedge clock);
        lat = 0;
        @(negedge clock);
        rdy4 = 1'b0;
        in4[2] = 32'h00630000;
        in4[3] = 32'h00640000;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        rdy4 = 1'b1;
        #1;
        wait_valid(lat);
        chk("midscan latency", 64'(lat), 64'd3);
        chk("midscan index", 64'(idx4), 64'd1);
        chk("midscan value", 64'(val4), 64'h00140000);
        repeat (4) @(posedge clock);
        #1;
        chk("midscan no rescan", 64'({vld4, bsy4}), 64'b10);
        @(negedge clock);
        rdy4 = 1'b0;

        // Reset pulse mid-scan with inputs_ready held high across release.
        @(negedge clock);
        in4[0] = 32'h00010000;
        in4[1] = 32'h00020000;
        in4[2] = 32'h00030000;
        in4[3] = 32'h00040000;
        rdy4 = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst mid idx/val", 64'({idx4, val4}), 64'd0);
        chk("rst mid vld/busy", 64'({vld4, bsy4}), 64'd0);
        @(negedge clock);
        in4[0] = 32'hFFFF0000;
        in4[1] = 32'h00008000;
        in4[2] = 32'hFFFE0000;
        in4[3] = 32'h00004000;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst release start", 64'(bsy4), 64'd1);
        lat = 0;
        wait_valid(lat);
        chk("rst rescan latency", 64'(lat), 64'd3);
        chk("rst rescan index", 64'(idx4), 64'd1);
        chk("rst rescan value", 64'(val4), 64'h00008000);
        @(negedge clock);
        rdy4 = 1'b0;

        q = {32'h80000000};
        run_scan("n1", 1, q, 0, 32'h80000000);
        chk("n1 busy", 64'(bsy1), 64'd0);

        for (int t = 0; t < 3; t++) begin
            q = {};
            for (int i = 0; i < 10; i++) q.push_back($urandom);
            if (t == 2) begin
                q[9] = 32'h7FFFFFFF;
                q[4] = 32'h7FFFFFFF;
            end
            e = ref_idx(q);
            run_scan($sformatf("n10_%0d", t), 10, q, e, q[e]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
